// File: rtl/counter_sched.sv
// counter_sched: round-robin two-client scheduler that fires the counter's tr/mode and waits for cf.
// Latency: gnt/tr/mode one edge after req; backpressure: level req is held until done, ignored while busy.
module counter_sched #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic mode0,
  input  logic mode1,
  input  logic cf,
  output logic tr,
  output logic mode,
  output logic gnt0,
  output logic gnt1,
  output logic done0,
  output logic done1,
  output logic timeout_err,
  output logic busy
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic          last, last_nxt;
  logic          owner, owner_nxt;
  logic          pick;
  logic          tr_nxt, mode_nxt, gnt0_nxt, gnt1_nxt;
  logic          done0_nxt, done1_nxt, timeout_err_nxt, busy_nxt;

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    last_nxt        = last;
    owner_nxt       = owner;
    tr_nxt          = 1'b0;
    mode_nxt        = mode;
    gnt0_nxt        = gnt0;
    gnt1_nxt        = gnt1;
    done0_nxt       = 1'b0;
    done1_nxt       = 1'b0;
    timeout_err_nxt = 1'b0;
    // On a tie the client that did not win last time gets the counter.
    pick            = (req0 && req1) ? ~last : req1;

    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_nxt = pick;
          last_nxt  = pick;
          mode_nxt  = pick ? mode1 : mode0;
          gnt0_nxt  = ~pick;
          gnt1_nxt  = pick;
          tr_nxt    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cf || (cnt == CNT_MAX)) begin
          done0_nxt       = ~owner;
          done1_nxt       = owner;
          timeout_err_nxt = ~cf;
          gnt0_nxt        = 1'b0;
          gnt1_nxt        = 1'b0;
          state_nxt       = S_DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last        <= 1'b1;
      owner       <= 1'b0;
      tr          <= 1'b0;
      mode        <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last        <= last_nxt;
      owner       <= owner_nxt;
      tr          <= tr_nxt;
      mode        <= mode_nxt;
      gnt0        <= gnt0_nxt;
      gnt1        <= gnt1_nxt;
      done0       <= done0_nxt;
      done1       <= done1_nxt;
      timeout_err <= timeout_err_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: doc/counter_sched.md
# counter_sched

Two-requester scheduler for the shared trigger counter. Arbitrates between two clients that each want a counting run in a chosen mode, issues the single-cycle `tr` pulse with the winner's `mode`, and waits for the counter's `cf` completion flag. Reports completion (or timeout) back to the granted client. Sits directly in front of the counter's `tr`/`mode` inputs; the counter's `cf` feeds back into it.

## Interface
- `TIMEOUT`, 64: maximum WAIT cycles without `cf` before abort; legal range 2..65535.
- `TW`, `$clog2(TIMEOUT)`: timeout counter width (derived; do not override).

- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req0`, `req1`  in  1 each  level request from client 0/1; held until `done` for that client.
- `mode0`, `mode1`  in  1 each  run mode requested by client 0/1; sampled at grant.
- `cf`  in  1  counter completion flag; one-cycle pulse from the counter.
- `tr`  out  1  trigger to counter; exactly one cycle per run.
- `mode`  out  1  mode to counter; valid from `tr` until run ends.
- `gnt0`, `gnt1`  out  1 each  client owns the counter (ISSUE and WAIT).
- `done0`, `done1`  out  1 each  one-cycle completion pulse to the owning client.
- `timeout_err`  out  1  one-cycle pulse coincident with `done` when the run was aborted.
- `busy`  out  1  high in any state except IDLE.

## Operation
- All outputs registered. Reset values: `tr`=0, `mode`=0, `gnt0`=`gnt1`=0, `done0`=`done1`=0, `timeout_err`=0, `busy`=0, state IDLE, wait counter 0, round-robin pointer `last`=1 (client 0 wins first tie).
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if neither req, stay. If one req, grant it. If both, grant client != `last`. On grant: latch `modeX` into `mode`, set `gntX`=1, `tr`=1, `last`=X, go ISSUE.
- ISSUE (one cycle): `tr` returns to 0, wait counter cleared, go WAIT. `cf` in ISSUE is ignored.
- WAIT: if `cf`=1, go DONE (normal). Else if wait counter == TIMEOUT-1, go DONE with abort. Else increment counter.
- DONE (one cycle): `doneX`=1 for owner, `timeout_err`=1 if aborted, `gntX`=0, `mode` held. Next: IDLE; all pulses cleared.
- `cf` outside WAIT (IDLE, ISSUE, DONE) is ignored, with no state change and no error.
- Requests changing during ISSUE/WAIT/DONE are ignored; the latched `mode` is not affected by `modeX` changes after grant.
- Client dropping `req` before `done`: run completes normally; `done` still pulses.
- `reset` mid-run: all outputs to reset values asynchronously; `done` not generated for the aborted run; `last` returns to 1.

## Timing
- Grant latency: `req` sampled high at edge k in IDLE → `gnt`, `tr`, `mode` valid after edge k.
- `tr` high for exactly the cycle between edges k and k+1.
- `cf` sampled high at edge m (in WAIT) → `done` high between edges m and m+1; `gnt` low from edge m.
- Earliest next grant: edge m+2. Minimum `tr`-to-`tr` spacing = run length + 3 cycles.
- Timeout: entering WAIT after edge k+1, abort DONE begins after edge k+1+TIMEOUT.
- At most one of `gnt0`/`gnt1` high; at most one of `done0`/`done1` high; `gnt` and `done` never both high for the same client.

## Test plan
- Reset: assert `reset` for 40 ns mid-WAIT → all outputs 0 within the same cycle, state IDLE, no `done` pulse.
- Single client: `req0`=1, `mode0`=0; counter model pulses `cf` 6 cycles after `tr` → one `tr` pulse with `mode`=0, `gnt0` for 8 cycles, `done0` one cycle, `timeout_err`=0.
- Mode capture: `req1`=1, `mode1`=1, then `mode1`→0 one cycle after grant → `mode` stays 1 until DONE; exactly one `tr`.
- Contention: `req0`=`req1`=1 held over four runs → grant order 0,1,0,1; `tr` spacing = run length + 3 cycles; never both `gnt` high.
- Timeout: TIMEOUT=8, `cf` never asserted → `done0` and `timeout_err` pulse together exactly 8 cycles after ISSUE; return to IDLE.
- Spurious `cf`: pulse `cf` in IDLE and in ISSUE → ignored; run still waits for a `cf` in WAIT.
